mac_dot_sequencer: RTL and testbench

Controller that sequences one external signed MAC datapath (16-bit data × 8-bit weight, 24-bit accumulator, clear-on-first, registered accumulate) through a K-element dot product. It accepts a length command, streams operand pairs into the MAC under valid/ready flow control, and asserts clear on the first element. It captures the final accumulator and presents it on a valid/ready result port. It sits between the operand fetch logic and the MAC in each systolic-array PE column.

---
 rtl/mac_dot_sequencer_pkg.sv | 19 +
 rtl/mac_dot_sequencer.sv | 122 ++++++++++++
 tb/tb_mac_dot_sequencer.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_dot_sequencer_pkg.sv
// mac_dot_sequencer_pkg
//   Shared definitions for the dot-product sequencer, the external MAC and
//   the PE array: sequencer state encoding and default operand/accumulator
//   widths.
package mac_dot_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

  localparam int DEF_DATA_WIDTH   = 16;
  localparam int DEF_WEIGHT_WIDTH = 8;
  localparam int DEF_ACCUM_WIDTH  = 24;
  localparam int DEF_LEN_WIDTH    = 8;

endpackage

// File: rtl/mac_dot_sequencer.sv
// mac_dot_sequencer
//   Drives one external signed MAC (clear-on-first, registered accumulate)
//   through a K-element dot product and returns the final accumulator.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   abort                    synchronous return to IDLE from any state
//   cmd_valid/ready, cmd_len length command (K may be 0)
//   op_valid/ready           operand pair stream
//   op_data, op_weight       signed activation / weight
//   mac_enable, mac_clear    MAC control (combinational, same cycle as op)
//   mac_data, mac_weight     pass-through operands to the MAC
//   mac_accum                MAC accumulator output
//   res_valid/ready, res_data registered result port
//   busy                     high whenever the sequencer is not IDLE
module mac_dot_sequencer
  import mac_dot_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int WEIGHT_WIDTH = DEF_WEIGHT_WIDTH,
  parameter int ACCUM_WIDTH  = DEF_ACCUM_WIDTH,
  parameter int LEN_WIDTH    = DEF_LEN_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           abort,
  input  logic                           cmd_valid,
  output logic                           cmd_ready,
  input  logic        [LEN_WIDTH-1:0]    cmd_len,
  input  logic                           op_valid,
  output logic                           op_ready,
  input  logic signed [DATA_WIDTH-1:0]   op_data,
  input  logic signed [WEIGHT_WIDTH-1:0] op_weight,
  output logic                           mac_enable,
  output logic                           mac_clear,
  output logic signed [DATA_WIDTH-1:0]   mac_data,
  output logic signed [WEIGHT_WIDTH-1:0] mac_weight,
  input  logic signed [ACCUM_WIDTH-1:0]  mac_accum,
  output logic                           res_valid,
  input  logic                           res_ready,
  output logic signed [ACCUM_WIDTH-1:0]  res_data,
  output logic                           busy
);

  localparam logic [LEN_WIDTH-1:0] LEN_ONE  = LEN_WIDTH'(1);
  localparam logic [LEN_WIDTH-1:0] LEN_ZERO = '0;

  seq_state_e           state;
  logic [LEN_WIDTH-1:0] len_reg;
  logic [LEN_WIDTH-1:0] cnt;
  logic                 op_fire;
  logic                 last_elem;

  // Handshake qualification: rst and abort both mask every ready/enable
  // in the cycle they are asserted, so no transfer can slip through.
  always_comb begin
    cmd_ready = 1'b0;
    op_ready  = 1'b0;
    if (!rst && !abort) begin
      cmd_ready = (state == ST_IDLE);
      op_ready  = (state == ST_RUN);
    end
  end

  assign op_fire    = op_valid && op_ready;
  assign last_elem  = (cnt == (len_reg - LEN_ONE));
  assign mac_enable = op_fire;
  assign mac_clear  = op_fire && (cnt == LEN_ZERO);
  assign mac_data   = op_data;
  assign mac_weight = op_weight;
  assign busy       = (state != ST_IDLE);

  // Control FSM, element counter and result register.
  // Zero-length commands also pass through DRAIN (loading zero instead of
  // the accumulator) so result latency is uniformly K+2 cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      len_reg   <= '0;
      cnt       <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
    end else if (abort) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      res_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            len_reg <= cmd_len;
            cnt     <= '0;
            state   <= (cmd_len != LEN_ZERO) ? ST_RUN : ST_DRAIN;
          end
        end
        ST_RUN: begin
          if (op_valid) begin
            // Exit compares against len_reg-1 so cnt never needs to wrap.
            cnt <= cnt + LEN_ONE;
            if (last_elem) begin
              state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          // MAC's registered accumulate has settled on the final sum here.
          res_data  <= (len_reg == LEN_ZERO) ? '0 : mac_accum;
          res_valid <= 1'b1;
          state     <= ST_DONE;
        end
        ST_DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// tb_mac_dot_sequencer
//   Directed bench for mac_dot_sequencer with a behavioural signed MAC and
//   a result scoreboard consumed by an independent monitor.
module tb_mac_dot_sequencer;

  logic               clk = 1'b0;
  logic               rst;
  logic               abort;
  logic               cmd_valid;
  logic               cmd_ready;
  logic        [7:0]  cmd_len;
  logic               op_valid;
  logic               op_ready;
  logic signed [15:0] op_data;
  logic signed [7:0]  op_weight;
  logic               mac_enable;
  logic               mac_clear;
  logic signed [15:0] mac_data;
  logic signed [7:0]  mac_weight;
  logic signed [23:0] mac_accum;
  logic               res_valid;
  logic               res_ready;
  logic signed [23:0] res_data;
  logic               busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int hs_cyc = 0;
  int exp_lat = 0;
  logic prev_rv = 1'b0;
  logic [23:0] exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mac_dot_sequencer dut (
    .clk(clk), .rst(rst), .abort(abort),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_data(op_data), .op_weight(op_weight),
    .mac_enable(mac_enable), .mac_clear(mac_clear),
    .mac_data(mac_data), .mac_weight(mac_weight), .mac_accum(mac_accum),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy)
  );

  // Behavioural external MAC: clear-on-first, registered accumulate.
  logic signed [23:0] acc = '0;
  logic signed [23:0] prod;
  assign prod      = mac_data * mac_weight;
  assign mac_accum = acc;
  always @(posedge clk) begin
    if (mac_enable) acc <= mac_clear ? prod : acc + prod;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: latency of each result and scoreboard pop on handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (res_valid && !prev_rv) chk("res_latency", cyc - hs_cyc, exp_lat);
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 32'd1, 32'd0);
        end else begin
          logic [23:0] got, e;
          got = res_data;
          e   = exp_q.pop_front();
          chk("res_data", {8'd0, got}, {8'd0, e});
        end
      end
    end
    prev_rv <= res_valid;
  end

  task automatic send_cmd(input logic [7:0] k, input int lat);
    cmd_valid = 1'b1;
    cmd_len   = k;
    exp_lat   = lat;
    @(negedge clk);
    chk("cmd_ready", {31'd0, cmd_ready}, 32'd1);
    hs_cyc = cyc;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic send_op(input logic signed [15:0] d, input logic signed [7:0] w,
                         input logic exp_clr);
    op_valid  = 1'b1;
    op_data   = d;
    op_weight = w;
    @(negedge clk);
    chk("mac_enable", {31'd0, mac_enable}, 32'd1);
    chk("mac_clear", {31'd0, mac_clear}, {31'd0, exp_clr});
    @(posedge clk); #1;
    op_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) begin
        done = 1;
        break;
      end
    end
    if (!done) chk("idle_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; abort = 1'b0; cmd_valid = 1'b0; cmd_len = '0;
    op_valid = 1'b0; op_data = '0; op_weight = '0; res_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_res_data", {8'd0, res_data}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // K=3: 2*5 + -3*6 + 4*-7 = -36
    exp_q.push_back(24'hFFFFDC);
    send_cmd(8'd3, 5);
    send_op(16'sd2, 8'sd5, 1'b1);
    send_op(-16'sd3, 8'sd6, 1'b0);
    send_op(16'sd4, -8'sd7, 1'b0);
    wait_idle();

    // K=1 back-to-back: 100 * -2 = -200, clear discards -36
    exp_q.push_back(24'hFFFF38);
    send_cmd(8'd1, 3);
    send_op(16'sd100, -8'sd2, 1'b1);
    wait_idle();

    // K=4 with a 2-cycle stall between elements 2 and 3
    exp_q.push_back(24'd4);
    send_cmd(8'd4, 8);
    send_op(16'sd1, 8'sd1, 1'b1);
    send_op(16'sd1, 8'sd1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("stall_mac_enable", {31'd0, mac_enable}, 32'd0);
      chk("stall_op_ready", {31'd0, op_ready}, 32'd1);
      @(posedge clk); #1;
    end
    send_op(16'sd1, 8'sd1, 1'b0);
    send_op(16'sd1, 8'sd1, 1'b0);
    wait_idle();

    // K=0 with result back-pressure
    exp_q.push_back(24'd0);
    res_ready = 1'b0;
    send_cmd(8'd0, 2);
    begin
      bit seen = 0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (res_valid) begin
          seen = 1;
          break;
        end
        chk("k0_mac_enable", {31'd0, mac_enable}, 32'd0);
      end
      if (!seen) chk("k0_res_timeout", 32'd1, 32'd0);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_len   = 8'd2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_res_valid", {31'd0, res_valid}, 32'd1);
      chk("hold_res_data", {8'd0, res_data}, 32'd0);
      chk("hold_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    wait_idle();

    // K=5 aborted after the 2nd element
    send_cmd(8'd5, 0);
    send_op(16'sd1, 8'sd1, 1'b1);
    send_op(16'sd1, 8'sd1, 1'b0);
    abort    = 1'b1;
    op_valid = 1'b1;
    @(negedge clk);
    chk("abort_mac_enable", {31'd0, mac_enable}, 32'd0);
    chk("abort_op_ready", {31'd0, op_ready}, 32'd0);
    @(posedge clk); #1;
    abort    = 1'b0;
    op_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_res_valid", {31'd0, res_valid}, 32'd0);
      @(posedge clk); #1;
    end

    // K=1 after abort: 3*3 = 9
    exp_q.push_back(24'd9);
    send_cmd(8'd1, 3);
    send_op(16'sd3, 8'sd3, 1'b1);
    wait_idle();

    // rst mid-RUN with an operand offered
    send_cmd(8'd3, 0);
    send_op(16'sd1, 8'sd1, 1'b1);
    rst      = 1'b1;
    op_valid = 1'b1;
    @(negedge clk);
    chk("rst_run_mac_enable", {31'd0, mac_enable}, 32'd0);
    chk("rst_run_op_ready", {31'd0, op_ready}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_run_busy", {31'd0, busy}, 32'd0);
    chk("rst_run_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_run_res_data", {8'd0, res_data}, 32'd0);
    chk("rst_run_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    @(posedge clk); #1;
    rst      = 1'b0;
    op_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;

    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
